// File: rtl/plugboard_pkg.sv
// Shared constants for the plugboard configuration controller: letter codes, FSM states, error codes.
package plugboard_pkg;

  localparam int LETTERS = 26;
  localparam int LTR_W   = 5;

  localparam logic [LTR_W-1:0] LTR_A = 5'd0;
  localparam logic [LTR_W-1:0] LTR_E = 5'd4;
  localparam logic [LTR_W-1:0] LTR_Z = 5'd25;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WAIT_A = 2'd1;
  localparam state_t ST_WAIT_B = 2'd2;
  localparam state_t ST_CLEAR  = 2'd3;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_RANGE  = 2'b01;
  localparam logic [1:0] ERR_IN_USE = 2'b10;
  localparam logic [1:0] ERR_FULL   = 2'b11;

endpackage

// File: rtl/plugboard_map_rd.sv
// Combinational swap-table read; codes outside the alphabet read as 0.
module plugboard_map_rd
  import plugboard_pkg::*;
#(
  parameter int LETTERS = plugboard_pkg::LETTERS
) (
  input  logic [LETTERS-1:0][LTR_W-1:0] map,
  input  logic [LTR_W-1:0]              lookup_in,
  output logic [LTR_W-1:0]              plugboard_out
);

  always_comb begin
    plugboard_out = '0;
    if (int'(lookup_in) < LETTERS) plugboard_out = map[lookup_in];
  end

endmodule

// File: rtl/plugboard_cfg_ctrl.sv
// Plugboard cable programming: keyboard pairs letters into an involutive swap table, clear_all sweeps it back.
// Optional PLUGBOARD_UNPLUG_EN: keying a plugged letter while waiting for a first letter removes its cable.
module plugboard_cfg_ctrl
  import plugboard_pkg::*;
#(
  parameter int MAX_PAIRS = 10,
  parameter int LETTERS   = plugboard_pkg::LETTERS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_mode,
  input  logic             key_valid,
  input  logic [LTR_W-1:0] keyboard,
  input  logic             clear_all,
  input  logic [LTR_W-1:0] lookup_in,
  output logic [LTR_W-1:0] plugboard_out,
  output logic [3:0]       pair_count,
  output logic             first_pending,
  output logic             busy,
  output logic             commit,
  output logic             err,
  output logic [1:0]       err_code
);

  state_t                       state;
  logic [LETTERS-1:0][LTR_W-1:0] map;
  logic [LTR_W-1:0]             first_ltr;
  logic [LTR_W-1:0]             clr_idx;
  logic [LTR_W-1:0]             key_partner;
  logic [LTR_W-1:0]             clr_partner;
  logic                         key_in_range;
  logic                         key_free;

  plugboard_map_rd #(.LETTERS(LETTERS)) u_map_rd (
    .map           (map),
    .lookup_in     (lookup_in),
    .plugboard_out (plugboard_out)
  );

  assign key_in_range  = int'(keyboard) < LETTERS;
  assign key_partner   = key_in_range ? map[keyboard] : keyboard;
  assign key_free      = (key_partner == keyboard);
  assign clr_partner   = map[clr_idx];
  assign first_pending = (state == ST_WAIT_B);
  assign busy          = (state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      for (int i = 0; i < LETTERS; i++) map[i] <= LTR_W'(i);
      pair_count <= '0;
      first_ltr  <= '0;
      clr_idx    <= '0;
      commit     <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      commit <= 1'b0;
      err    <= 1'b0;
      if (clear_all) begin
        state   <= ST_CLEAR;
        clr_idx <= '0;
      end else begin
        case (state)
          ST_IDLE: if (cfg_mode) state <= ST_WAIT_A;

          ST_WAIT_A: begin
            if (!cfg_mode) begin
              state <= ST_IDLE;
            end else if (key_valid) begin
              if (!key_in_range) begin
                err      <= 1'b1;
                err_code <= ERR_RANGE;
              end else if (!key_free) begin
`ifdef PLUGBOARD_UNPLUG_EN
                map[keyboard]    <= keyboard;
                map[key_partner] <= key_partner;
                pair_count       <= pair_count - 4'd1;
                commit           <= 1'b1;
`else
                err      <= 1'b1;
                err_code <= ERR_IN_USE;
`endif
              end else if (pair_count == 4'(MAX_PAIRS)) begin
                err      <= 1'b1;
                err_code <= ERR_FULL;
              end else begin
                first_ltr <= keyboard;
                state     <= ST_WAIT_B;
              end
            end
          end

          ST_WAIT_B: begin
            if (!cfg_mode) begin
              state <= ST_IDLE;
            end else if (key_valid) begin
              if (!key_in_range) begin
                err      <= 1'b1;
                err_code <= ERR_RANGE;
              end else if (keyboard == first_ltr) begin
                state <= ST_WAIT_A;
              end else if (!key_free) begin
                err      <= 1'b1;
                err_code <= ERR_IN_USE;
              end else begin
                // Both ends land on the same edge so the table never shows half a cable
                map[first_ltr] <= keyboard;
                map[keyboard]  <= first_ltr;
                pair_count     <= pair_count + 4'd1;
                commit         <= 1'b1;
                state          <= ST_WAIT_A;
              end
            end
          end

          ST_CLEAR: begin
            // Restoring the partner along with the entry keeps the table an involution mid-sweep
            map[clr_idx]     <= clr_idx;
            map[clr_partner] <= clr_partner;
            if (clr_idx == LTR_W'(LETTERS - 1)) begin
              pair_count <= '0;
              state      <= cfg_mode ? ST_WAIT_A : ST_IDLE;
            end else begin
              clr_idx <= clr_idx + 1'b1;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_plugboard_cfg_ctrl.sv
// Directed bench with a per-cycle behavioural model of the cable table and hand-computed spot checks.
module tb_plugboard_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst, cfg_mode, key_valid, clear_all;
  logic [4:0] keyboard, lookup_in;
  logic [4:0] plugboard_out;
  logic [3:0] pair_count;
  logic       first_pending, busy, commit, err;
  logic [1:0] err_code;

  plugboard_cfg_ctrl #(.MAX_PAIRS(10), .LETTERS(26)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .key_valid(key_valid), .keyboard(keyboard),
    .clear_all(clear_all), .lookup_in(lookup_in), .plugboard_out(plugboard_out),
    .pair_count(pair_count), .first_pending(first_pending), .busy(busy), .commit(commit),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain arrays and counters, updated at each rising edge from the inputs
  int mmap[26];
  int pend, clear_left, clr_next, cnt, e_code;
  bit in_cfg, e_commit, e_err;

  always @(posedge clk) begin
    int k, p;
    e_commit = 0;
    e_err    = 0;
    k        = int'(keyboard);
    if (rst) begin
      for (int i = 0; i < 26; i++) mmap[i] = i;
      pend = -1; in_cfg = 0; clear_left = 0; clr_next = 0; cnt = 0; e_code = 0;
    end else if (clear_all) begin
      clear_left = 26; clr_next = 0; pend = -1;
    end else if (clear_left > 0) begin
      p = mmap[clr_next];
      mmap[clr_next] = clr_next;
      mmap[p] = p;
      clr_next++;
      clear_left--;
      if (clear_left == 0) begin cnt = 0; in_cfg = cfg_mode; end
    end else if (!in_cfg) begin
      in_cfg = cfg_mode;
    end else if (!cfg_mode) begin
      in_cfg = 0; pend = -1;
    end else if (key_valid) begin
      if (k > 25) begin
        e_err = 1; e_code = 1;
      end else if (pend < 0) begin
        if (mmap[k] != k) begin
`ifdef PLUGBOARD_UNPLUG_EN
          p = mmap[k]; mmap[k] = k; mmap[p] = p; cnt--; e_commit = 1;
`else
          e_err = 1; e_code = 2;
`endif
        end else if (cnt == 10) begin
          e_err = 1; e_code = 3;
        end else begin
          pend = k;
        end
      end else if (k == pend) begin
        pend = -1;
      end else if (mmap[k] != k) begin
        e_err = 1; e_code = 2;
      end else begin
        mmap[pend] = k; mmap[k] = pend; cnt++; e_commit = 1; pend = -1;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("cyc_pair_count", pair_count, cnt);
      check("cyc_first_pending", first_pending, pend >= 0);
      check("cyc_busy", busy, clear_left > 0);
      check("cyc_commit", commit, e_commit);
      check("cyc_err", err, e_err);
      check("cyc_err_code", err_code, e_code);
      check("cyc_plugboard_out", plugboard_out, (lookup_in > 25) ? 0 : mmap[lookup_in]);
    end
  end

  task automatic press(input int k);
    @(negedge clk);
    keyboard  = 5'(k);
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    check({tag, "_pair_count"}, pair_count, 0);
    check({tag, "_first_pending"}, first_pending, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_commit"}, commit, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_err_code"}, err_code, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int pa[9] = '{1, 3, 6, 8, 10, 12, 14, 16, 18};
  int pb[9] = '{2, 5, 7, 9, 11, 13, 15, 17, 19};
  int nb;

  initial begin
    rst = 1; cfg_mode = 0; key_valid = 0; keyboard = 0; clear_all = 0; lookup_in = 0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    check_reset_outputs("reset");
    rst = 0;

    // Identity table after reset, out-of-range lookup reads 0
    for (int i = 0; i < 26; i++) begin
      @(negedge clk); lookup_in = 5'(i);
      #1 check("ident_lookup", plugboard_out, i);
    end
    @(negedge clk); lookup_in = 5'd30;
    #1 check("lookup_30", plugboard_out, 0);

    // Pair a-e
    @(negedge clk); cfg_mode = 1;
    press(0);
    #1 check("a_first_pending", first_pending, 1);
    press(4);
    #1 check("ae_commit", commit, 1);
    check("ae_pair_count", pair_count, 1);
    lookup_in = 5'd0;
    #1 check("ae_lookup_a", plugboard_out, 4);
    @(negedge clk); lookup_in = 5'd4;
    #1 check("ae_lookup_e", plugboard_out, 0);

    // Second letter already in use, then cancel, then self-cancel on d
    press(7);
    press(0);
    #1 check("inuse_err", err, 1);
    check("inuse_code", err_code, 2);
    check("inuse_stay_b", first_pending, 1);
    press(7);
    #1 check("cancel7_pending", first_pending, 0);
    press(3);
    #1 check("d_pending", first_pending, 1);
    press(3);
    #1 check("dd_pending", first_pending, 0);
    check("dd_no_err", err, 0);

    // Out-of-range key
    press(31);
    #1 check("range_err", err, 1);
    check("range_code", err_code, 1);

    // Fill to ten pairs, then one more first letter must be refused
    for (int i = 0; i < 9; i++) begin
      press(pa[i]);
      press(pb[i]);
    end
    #1 check("full_count", pair_count, 10);
    press(24);
    #1 check("full_err", err, 1);
    check("full_code", err_code, 3);
    check("full_count_hold", pair_count, 10);
    @(negedge clk);
    #1 check("err_pulse_drop", err, 0);
    check("err_code_held", err_code, 3);

    // clear_all wins over a simultaneous key
    @(negedge clk);
    clear_all = 1; key_valid = 1; keyboard = 5'd20;
    @(negedge clk);
    clear_all = 0; key_valid = 0;
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    check("clear_busy_cycles", nb, 26);
    #1 check("clear_count", pair_count, 0);
    for (int i = 0; i < 26; i++) begin
      @(negedge clk); lookup_in = 5'(i);
      #1 check("clear_ident", plugboard_out, i);
    end

    // Re-pair a-e, then key e from WAIT_A
    press(0);
    press(4);
    press(4);
`ifdef PLUGBOARD_UNPLUG_EN
    #1 check("unplug_commit", commit, 1);
    check("unplug_count", pair_count, 0);
    check("unplug_no_err", err, 0);
    lookup_in = 5'd0;
    #1 check("unplug_a", plugboard_out, 0);
    @(negedge clk); lookup_in = 5'd4;
    #1 check("unplug_e", plugboard_out, 4);
`else
    #1 check("nounplug_err", err, 1);
    check("nounplug_code", err_code, 2);
    check("nounplug_count", pair_count, 1);
`endif

    // Reset at clear cycle 10
    press(1);
    press(2);
    @(negedge clk); clear_all = 1;
    @(negedge clk); clear_all = 0;
    repeat (9) @(negedge clk);
    check("midclear_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    check_reset_outputs("rst_midclear");
    rst = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk); lookup_in = 5'(i);
      #1 check("rst_clear_ident", plugboard_out, i);
    end

    // Reset in the middle of a pair
    press(0);
    press(4);
    press(31);
    press(5);
    #1 check("midpair_pending", first_pending, 1);
    @(negedge clk); rst = 1;
    @(negedge clk);
    check_reset_outputs("rst_midpair");
    rst = 0;
    lookup_in = 5'd0;
    #1 check("rst_pair_a", plugboard_out, 0);
    @(negedge clk); lookup_in = 5'd4;
    #1 check("rst_pair_e", plugboard_out, 4);
    repeat (3) @(negedge clk);

    chk_en = 0;
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/plugboard_cfg_ctrl.md
PLUGBOARD_CFG_CTRL -- requirements
Module: plugboard_cfg_ctrl

Interface
REQ-001 SHALL have parameter MAX_PAIRS, default 10, meaning maximum number of simultaneous cable pairs (1..13).
REQ-002 SHALL have parameter LETTERS, default 26, meaning alphabet size; letter codes are 0 (a) .. 25 (z).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port cfg_mode, input, 1, meaning plug programming is enabled while high.
REQ-006 SHALL have port key_valid, input, 1, a one-cycle strobe qualifying keyboard.
REQ-007 SHALL have port keyboard, input, 5, the pressed letter code.
REQ-008 SHALL have port clear_all, input, 1, a request to remove all cables.
REQ-009 SHALL have port lookup_in, input, 5, the letter to translate (datapath side).
REQ-010 SHALL have port plugboard_out, output, 5, the swapped letter for lookup_in.
REQ-011 SHALL have port pair_count, output, 4, the number of installed pairs.
REQ-012 SHALL have port first_pending, output, 1, high while the first letter of a pair is latched.
REQ-013 SHALL have port busy, output, 1, high during the clear sweep.
REQ-014 SHALL have port commit, output, 1, a one-cycle pulse when a pair is installed or removed.
REQ-015 SHALL have ports err, output, 1 (one-cycle pulse), and err_code, output, 2 (01 range, 10 letter in use, 11 table full; held until the next err).

Function
REQ-016 SHALL hold a LETTERS-entry swap table map[], where map[i]==i means unplugged.
REQ-017 SHALL drive plugboard_out = map[lookup_in] combinationally, and 0 when lookup_in > 25.
REQ-018 SHALL implement the FSM states IDLE, WAIT_A, WAIT_B and CLEAR.
REQ-019 IDLE SHALL go to WAIT_A when cfg_mode=1; WAIT_A and WAIT_B SHALL go to IDLE when cfg_mode=0, dropping any latched letter.
REQ-020 In any state, clear_all SHALL enter CLEAR, and it SHALL take priority over a simultaneous key_valid.
REQ-021 CLEAR SHALL write map[idx]=idx for idx=0..25, one entry per cycle, with busy=1 for exactly 26 cycles; it SHALL then set pair_count=0 and go to WAIT_A or IDLE according to cfg_mode.
REQ-022 key_valid SHALL be ignored in IDLE and in CLEAR.
REQ-023 In WAIT_A or WAIT_B, a keyboard value > 25 SHALL pulse err with code 01 and leave the state unchanged.
REQ-024 In WAIT_A, if map[k]!=k, the block SHALL pulse err with code 10; if pair_count==MAX_PAIRS, it SHALL pulse err with code 11; otherwise it SHALL latch k and go to WAIT_B with first_pending=1.
REQ-025 In WAIT_B, a key equal to the latched letter SHALL cancel silently and return to WAIT_A.
REQ-026 In WAIT_B, a key already in use SHALL pulse err with code 10 and remain in WAIT_B.
REQ-027 Otherwise in WAIT_B, the block SHALL write map[a]=b and map[b]=a in the same edge, increment pair_count, pulse commit and return to WAIT_A.
REQ-028 Table, pair_count, err and commit SHALL be visible the cycle after the key_valid edge; this is 1-cycle latency.
REQ-029 The table SHALL always remain an involution; no partial pair SHALL ever be visible on plugboard_out.

Reset
REQ-030 rst SHALL set map[i]=i, the state to IDLE, pair_count=0, and first_pending, busy, commit, err and err_code to 0.
REQ-031 rst SHALL override clear_all and key_valid, including mid-CLEAR and mid-pair.

Configuration
REQ-032 With PLUGBOARD_UNPLUG_EN defined, a WAIT_A key on a letter in use SHALL restore both ends to identity, decrement pair_count and pulse commit, with no err.
REQ-033 Without PLUGBOARD_UNPLUG_EN, that case SHALL give err code 10, and only CLEAR removes cables.

Structure
REQ-034 A shared package plugboard_pkg SHALL hold LETTERS, the letter-code constants, the FSM state enum and the err_code constants.
REQ-035 A combinational sub-module plugboard_map_rd (the table read plus out-of-range handling) SHALL be used; everything else SHALL stay in plugboard_cfg_ctrl.

Verification
REQ-036 Reset, then lookup_in 0..25 -> plugboard_out equals lookup_in, and lookup_in=30 -> 0.
REQ-037 cfg_mode=1; keys 0 (a) then 4 (e) -> commit, pair_count=1, lookup 0->4 and 4->0.
REQ-038 Keys 0 then 7 with a already paired -> err code 10; keys 3 then 3 -> first_pending falls, no err.
REQ-039 Install 10 pairs, then key 24 -> err code 11, pair_count stays 10; clear_all together with key_valid -> busy for 26 cycles, then pair_count=0 and the table is identity.
REQ-040 Key 31 -> err code 01; with PLUGBOARD_UNPLUG_EN, key 4 on pair a-e -> commit, pair_count-1, a and e map to themselves.
REQ-041 rst asserted at CLEAR cycle 10 and again in WAIT_B -> all outputs at reset values the next cycle, and the table is identity.
